// File: rtl/control_booth.sv
// Sequential radix-2 signed Booth multiplier with its controller; N+1 clocks from the start edge to product/listo.
// No backpressure: start edges arriving while a run is in progress are dropped, and the result is held until the next start.
module control_booth #(
    parameter int N = 8
) (
    input  logic             CLK100MHZ,
    input  logic             reset,
    input  logic             pb_salida,
    input  logic [N-1:0]     multiplicando,
    input  logic [N-1:0]     multiplicador,
    output logic [2*N-1:0]   producto,
    output logic             listo,
    output logic             ocupado
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic             pb_q, pb_d;
    logic [N:0]       a_q, a_d;
    logic [N-1:0]     q_q, q_d;
    logic             q1_q, q1_d;
    logic [N:0]       m_q, m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*N-1:0]   prod_q, prod_d;
    logic             listo_q, listo_d;

    logic             start;
    logic             last_step;
    logic             load_ops;
    logic             calc_step;
    logic             store_res;
    logic [N:0]       a_sum;

    assign start     = pb_salida & ~pb_q;
    assign last_step = (cnt_q == CNT_W'(N - 1));

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (last_step) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ocupado   = 1'b0;
        load_ops  = 1'b0;
        calc_step = 1'b0;
        store_res = 1'b0;
        case (state_q)
            IDLE: load_ops = start;
            CALC: begin
                ocupado   = 1'b1;
                calc_step = 1'b1;
            end
            DONE: begin
                ocupado   = 1'b1;
                store_res = 1'b1;
            end
            default: ;
        endcase
    end

    // A and M carry one extra sign bit so that subtracting M = -2^(N-1) cannot overflow.
    always_comb begin
        a_sum   = a_q;
        pb_d    = pb_salida;
        a_d     = a_q;
        q_d     = q_q;
        q1_d    = q1_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        listo_d = listo_q;

        case ({q_q[0], q1_q})
            2'b01:   a_sum = a_q + m_q;
            2'b10:   a_sum = a_q - m_q;
            default: a_sum = a_q;
        endcase

        if (load_ops) begin
            m_d     = {multiplicando[N-1], multiplicando};
            q_d     = multiplicador;
            a_d     = '0;
            q1_d    = 1'b0;
            cnt_d   = '0;
            listo_d = 1'b0;
        end

        if (calc_step) begin
            a_d   = {a_sum[N], a_sum[N:1]};
            q_d   = {a_sum[0], q_q[N-1:1]};
            q1_d  = q_q[0];
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (store_res) begin
            prod_d  = {a_q[N-1:0], q_q};
            listo_d = 1'b1;
        end
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            pb_q    <= 1'b0;
            a_q     <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            m_q     <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            listo_q <= 1'b0;
        end else begin
            pb_q    <= pb_d;
            a_q     <= a_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            listo_q <= listo_d;
        end
    end

    assign producto = prod_q;
    assign listo    = listo_q;

endmodule

// File: tb/tb_control_booth.sv
// Bench for control_booth: press stimulus queues the hand-computed product and its arrival cycle;
// a monitor pops and compares on each rising edge of listo.
module tb_control_booth;

    localparam int N = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             pb;
    logic [N-1:0]     mcand;
    logic [N-1:0]     mplier;
    logic [2*N-1:0]   producto;
    logic             listo;
    logic             ocupado;

    control_booth #(.N(N)) dut (
        .CLK100MHZ     (clk),
        .reset         (reset),
        .pb_salida     (pb),
        .multiplicando (mcand),
        .multiplicador (mplier),
        .producto      (producto),
        .listo         (listo),
        .ocupado       (ocupado)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] prod;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic listo_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Drive from a falling edge: the next rising edge samples the start, and the
    // result is visible at the falling edge ten rising edges later.
    task automatic press(input logic [7:0] m, input logic [7:0] q, input logic [15:0] e,
                         input bit run, input int hold);
        mcand  = m;
        mplier = q;
        pb     = 1'b1;
        if (run) exp_q.push_back('{prod: e, cyc: cyc + 10});
        repeat (hold) @(negedge clk);
        pb = 1'b0;
    endtask

    always @(negedge clk) begin
        if (listo === 1'b1 && listo_prev !== 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %0h expected no result", producto);
            end else begin
                mon_e = exp_q.pop_front();
                chk("product", 32'(producto), 32'(mon_e.prod));
                chk("latency", 32'(cyc), 32'(mon_e.cyc));
            end
        end
        listo_prev = listo;
    end

    int c0;

    initial begin
        reset  = 1'b1;
        pb     = 1'b0;
        mcand  = '0;
        mplier = '0;
        #1;
        chk("rst_producto", 32'(producto), 32'h0);
        chk("rst_listo",    32'(listo),    32'h0);
        chk("rst_ocupado",  32'(ocupado),  32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        press(8'h03, 8'h05, 16'h000F, 1'b1, 1);
        repeat (12) @(negedge clk);

        press(8'h80, 8'h80, 16'h4000, 1'b1, 1);
        chk("listo_drop", 32'(listo),    32'h0);
        chk("prod_held",  32'(producto), 32'h000F);
        chk("busy_calc",  32'(ocupado),  32'h1);
        repeat (12) @(negedge clk);

        press(8'hFF, 8'h7F, 16'hFF81, 1'b1, 1);
        repeat (12) @(negedge clk);
        press(8'h7F, 8'h80, 16'hC080, 1'b1, 1);
        repeat (12) @(negedge clk);
        press(8'h7F, 8'h7F, 16'h3F01, 1'b1, 1);
        repeat (12) @(negedge clk);
        press(8'h00, 8'h9C, 16'h0000, 1'b1, 1);
        repeat (12) @(negedge clk);

        // Held button with operands changed mid-run: one result, from the sampled operands.
        c0 = cyc;
        mcand  = 8'h0C;
        mplier = 8'hF3;
        pb     = 1'b1;
        exp_q.push_back('{prod: 16'hFF64, cyc: c0 + 10});
        repeat (3) @(negedge clk);
        mcand  = 8'h55;
        mplier = 8'h55;
        repeat (6) @(negedge clk);
        chk("hold_busy_done", 32'(ocupado), 32'h1);
        @(negedge clk);
        chk("hold_idle", 32'(ocupado), 32'h0);
        repeat (990) @(negedge clk);
        chk("hold_no_retrigger", 32'(ocupado), 32'h0);
        pb = 1'b0;
        repeat (3) @(negedge clk);

        // Second press during CALC must be dropped.
        press(8'hF9, 8'h06, 16'hFFD6, 1'b1, 2);
        repeat (2) @(negedge clk);
        mcand  = 8'h11;
        mplier = 8'h11;
        pb     = 1'b1;
        repeat (2) @(negedge clk);
        pb = 1'b0;
        repeat (12) @(negedge clk);
        chk("repress_idle", 32'(ocupado), 32'h0);

        // Reset in the fourth CALC cycle aborts the run with no partial result.
        press(8'h25, 8'h03, 16'h0000, 1'b0, 1);
        repeat (3) @(negedge clk);
        chk("abort_busy", 32'(ocupado), 32'h1);
        reset = 1'b1;
        #1;
        chk("abort_producto", 32'(producto), 32'h0);
        chk("abort_listo",    32'(listo),    32'h0);
        chk("abort_ocupado",  32'(ocupado),  32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort_stays_idle", 32'(ocupado), 32'h0);
        chk("abort_no_result",  32'(listo),   32'h0);

        press(8'hF6, 8'h0A, 16'hFF9C, 1'b1, 1);
        repeat (12) @(negedge clk);

        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
